// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register indices for the rename stage.
// Hands out up to ALLOC_WIDTH registers per cycle and accepts up to FREE_WIDTH returns from commit.
module phys_reg_freelist #(
  parameter int ALLOC_WIDTH = 2,
  parameter int FREE_WIDTH  = 2,
  parameter int PHYS_REGS   = 128,
  parameter int ARCH_REGS   = 32,
  parameter int PREG_W      = $clog2(PHYS_REGS),
  parameter int CNT_W       = $clog2(PHYS_REGS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ALLOC_WIDTH-1:0]        alloc_req,
  output logic                          alloc_ready,
  output logic [ALLOC_WIDTH*PREG_W-1:0] alloc_preg,
  input  logic [FREE_WIDTH-1:0]         free_en,
  input  logic [FREE_WIDTH*PREG_W-1:0]  free_preg,
  output logic [CNT_W-1:0]              free_count,
  output logic                          empty
);

  localparam int INIT_FREE = PHYS_REGS - ARCH_REGS;

  logic [PREG_W-1:0] entry_q [PHYS_REGS];
  logic [PREG_W-1:0] head_q;
  logic [PREG_W-1:0] tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              empty_q;

  logic [CNT_W-1:0]  alloc_cnt;
  logic [CNT_W-1:0]  free_cnt;
  logic [PREG_W-1:0] alloc_off [ALLOC_WIDTH];
  logic [PREG_W-1:0] free_off  [FREE_WIDTH];
  logic [FREE_WIDTH-1:0] free_acc;
  logic              fire;
  logic [CNT_W:0]    count_sum;
  logic [CNT_W-1:0]  count_next;

  assign free_count = count_q;
  assign empty      = empty_q;

  // Each requesting lane takes the entry offset by the number of lower requesting lanes.
  always_comb begin
    alloc_cnt = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_off[i] = PREG_W'(alloc_cnt);
      if (alloc_req[i]) alloc_cnt = alloc_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      free_off[j] = PREG_W'(free_cnt);
      free_acc[j] = free_en[j] && (free_preg[j*PREG_W +: PREG_W] != '0);
      if (free_acc[j]) free_cnt = free_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    alloc_preg = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      if (alloc_req[i]) alloc_preg[i*PREG_W +: PREG_W] = entry_q[head_q + alloc_off[i]];
    end
  end

  assign alloc_ready = (count_q >= alloc_cnt);
  assign fire        = (|alloc_req) && alloc_ready;

  // Freed registers only become visible next cycle; overflow clamps at PHYS_REGS-1.
  always_comb begin
    count_sum = {1'b0, count_q} - {1'b0, (fire ? alloc_cnt : CNT_W'(0))} + {1'b0, free_cnt};
    if (count_sum > (CNT_W+1)'(PHYS_REGS - 1)) count_next = CNT_W'(PHYS_REGS - 1);
    else                                       count_next = count_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PHYS_REGS; k++) begin
        entry_q[k] <= (k < INIT_FREE) ? PREG_W'(ARCH_REGS + k) : '0;
      end
      head_q  <= '0;
      tail_q  <= PREG_W'(INIT_FREE);
      count_q <= CNT_W'(INIT_FREE);
      empty_q <= (INIT_FREE == 0);
    end else begin
      if (fire) head_q <= head_q + PREG_W'(alloc_cnt);
      for (int j = 0; j < FREE_WIDTH; j++) begin
        if (free_acc[j]) entry_q[tail_q + free_off[j]] <= free_preg[j*PREG_W +: PREG_W];
      end
      tail_q  <= tail_q + PREG_W'(free_cnt);
      count_q <= count_next;
      empty_q <= (count_next == '0);
    end
  end

  free_overflow_chk: assert property (@(posedge clk) disable iff (rst)
    count_sum <= (CNT_W+1)'(PHYS_REGS - 1));

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Directed bench for phys_reg_freelist: reset, dense/sparse allocation, stall, boundaries,
// wrap-around with a queue reference model, and mid-stream reset.
module tb_phys_reg_freelist;

  localparam int PW = 7;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    alloc_req;
  logic          alloc_ready;
  logic [2*PW-1:0] alloc_preg;
  logic [1:0]    free_en;
  logic [2*PW-1:0] free_preg;
  logic [CW-1:0] free_count;
  logic          empty;

  int n_checks = 0;
  int n_errors = 0;

  phys_reg_freelist dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (alloc_req),
    .alloc_ready (alloc_ready),
    .alloc_preg  (alloc_preg),
    .free_en     (free_en),
    .free_preg   (free_preg),
    .free_count  (free_count),
    .empty       (empty)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lane(input int i);
    return int'(alloc_preg[i*PW +: PW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] fen, input int f0, input int f1);
    alloc_req = req;
    free_en   = fen;
    free_preg = {PW'(f1), PW'(f0)};
  endtask

  int fl[$];
  int held[$];

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_count", free_count, 96);
    chk("reset_empty", empty, 0);
    chk("reset_ready", alloc_ready, 1);

    // Dense allocation from reset
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 2'b00, 0, 0);
      #1;
      chk("dense_lane0", lane(0), 32 + 2*c);
      chk("dense_lane1", lane(1), 33 + 2*c);
      tick();
      chk("dense_count", free_count, 94 - 2*c);
    end

    // Sparse request: only lane 1 takes an entry
    drive(2'b10, 2'b00, 0, 0);
    #1;
    chk("sparse_lane0", lane(0), 0);
    chk("sparse_lane1", lane(1), 38);
    tick();
    chk("sparse_count", free_count, 89);

    // Drain down to one remaining register
    drive(2'b11, 2'b00, 0, 0);
    #1;
    chk("drain_first0", lane(0), 39);
    chk("drain_first1", lane(1), 40);
    for (int c = 0; c < 44; c++) tick();
    chk("drain_count", free_count, 1);

    // Stall with one free in the same cycle
    drive(2'b11, 2'b01, 40, 0);
    #1;
    chk("stall_ready", alloc_ready, 0);
    tick();
    drive(2'b11, 2'b00, 0, 0);
    #1;
    chk("stall_count", free_count, 2);
    chk("unstall_ready", alloc_ready, 1);
    chk("unstall_lane0", lane(0), 127);
    chk("unstall_lane1", lane(1), 40);
    tick();
    drive(2'b00, 2'b00, 0, 0);
    #1;
    chk("zero_count", free_count, 0);
    chk("zero_empty", empty, 1);
    chk("zero_ready_idle", alloc_ready, 1);

    // At zero: request stalls, free-only refills
    drive(2'b01, 2'b11, 33, 34);
    #1;
    chk("zero_ready_req", alloc_ready, 0);
    tick();
    drive(2'b00, 2'b00, 0, 0);
    #1;
    chk("refill_count", free_count, 2);
    chk("refill_empty", empty, 0);

    // Alloc 2 and free {5, p0} together
    drive(2'b11, 2'b11, 5, 0);
    #1;
    chk("mix_lane0", lane(0), 33);
    chk("mix_lane1", lane(1), 34);
    tick();
    drive(2'b01, 2'b00, 0, 0);
    #1;
    chk("mix_count", free_count, 1);
    chk("tail_lane0", lane(0), 5);
    chk("tail_lane1", lane(1), 0);
    tick();
    drive(2'b00, 2'b00, 0, 0);
    #1;
    chk("tail_count", free_count, 0);

    // Every nonzero register is now in use; exercise wrap with a queue reference
    for (int r = 1; r < 128; r++) held.push_back(r);
    for (int c = 0; c < 400; c++) begin
      logic [1:0] req;
      logic [1:0] fen;
      int f0, f1, nf, pc, nx;
      int got[2];
      bit rdy;
      req = 2'($urandom_range(0, 3));
      nf  = $urandom_range(0, 2);
      if (nf > held.size()) nf = held.size();
      fen = 2'b00; f0 = 0; f1 = 0;
      if (nf >= 1) begin fen[0] = 1'b1; f0 = held.pop_front(); end
      if (nf == 2) begin fen[1] = 1'b1; f1 = held.pop_front(); end
      else if ($urandom_range(0, 3) == 0) fen[1] = 1'b1;
      drive(req, fen, f0, f1);
      #1;
      pc  = int'(req[0]) + int'(req[1]);
      rdy = (fl.size() >= pc);
      chk("wrap_ready", alloc_ready, int'(rdy));
      nx = 0;
      for (int i = 0; i < 2; i++) begin
        got[i] = lane(i);
        if (!req[i]) chk("wrap_idle_lane", got[i], 0);
        else if (rdy) begin
          chk("wrap_alloc", got[i], fl[nx]);
          nx++;
        end
      end
      tick();
      if (rdy) begin
        for (int i = 0; i < 2; i++) begin
          if (req[i]) begin
            void'(fl.pop_front());
            held.push_back(got[i]);
          end
        end
      end
      if (fen[0] && f0 != 0) fl.push_back(f0);
      if (fen[1] && f1 != 0) fl.push_back(f1);
      chk("wrap_count", free_count, fl.size());
      chk("wrap_empty", empty, int'(fl.size() == 0));
    end

    // Asynchronous reset while requests are active
    drive(2'b11, 2'b11, 1, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_count", free_count, 96);
    chk("async_empty", empty, 0);
    tick();
    rst = 1'b0;
    drive(2'b11, 2'b00, 0, 0);
    #1;
    chk("post_rst_count", free_count, 96);
    chk("post_rst_lane0", lane(0), 32);
    chk("post_rst_lane1", lane(1), 33);
    tick();
    chk("post_rst_alloc", free_count, 94);
    drive(2'b00, 2'b00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/phys_reg_freelist.md
Name: phys_reg_freelist

Overview:
- Multi-port physical-register free list for the rename stage of the out-of-order core.
- Generalises the core's fixed dispatch and physical-register sizing into a parametrised circular FIFO.
  - Up to ALLOC_WIDTH physical registers are handed to rename per cycle.
  - Up to FREE_WIDTH registers are returned from commit per cycle.
- Sits between the rename table (consumer) and the ROB commit logic (producer of freed registers).

Parameters:
- ALLOC_WIDTH, default 2 (DISPATCH_WIDTH): allocation lanes per cycle.
- FREE_WIDTH, default 2: free/return lanes per cycle.
- PHYS_REGS, default 128: number of physical registers; power of two, ≥ 2*ARCH_REGS.
- ARCH_REGS, default 32: architectural registers. p0..p(ARCH_REGS-1) are mapped at reset.
- PREG_W, default $clog2(PHYS_REGS) = 7: physical register index width.
- CNT_W, default $clog2(PHYS_REGS+1) = 8: free-count width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req  in  ALLOC_WIDTH  per-lane allocation request; may be sparse.
- alloc_ready  out  1  high when free_count ≥ popcount(alloc_req); combinational.
- alloc_preg  out  ALLOC_WIDTH*PREG_W  lane i register index, valid when alloc_req[i] && alloc_ready.
- free_en  in  FREE_WIDTH  per-lane free strobe.
- free_preg  in  FREE_WIDTH*PREG_W  lane i register to return.
- free_count  out  CNT_W  registers currently allocatable (registered).
- empty  out  1  free_count == 0 (registered).

Behaviour:
- Storage:
  - PHYS_REGS-entry array with head/tail pointers, each PREG_W bits; pointers wrap naturally.
  - free_count is a separate CNT_W register.
- Reset (async, whenever rst is high, including mid-operation):
  - Entry k = ARCH_REGS+k for k < PHYS_REGS-ARCH_REGS; other entries are 0.
  - head = 0; tail = PHYS_REGS-ARCH_REGS (mod PHYS_REGS).
  - free_count = PHYS_REGS-ARCH_REGS (96); empty = 0; alloc_ready reflects the reset count.
  - Pending requests in the reset cycle are discarded.
- Allocation (all-or-nothing):
  - Fire = |alloc_req && alloc_ready.
  - The n-th set bit of alloc_req (lane order, lowest first) receives entry[head+n].
  - alloc_preg is combinational from the current head, zero added latency. Lanes with alloc_req=0 drive 0.
  - On fire: head += popcount(alloc_req), free_count -= popcount(alloc_req).
  - alloc_ready=0: no state change, alloc_preg undefined; rename must stall and hold its request.
- Free:
  - Each lane with free_en=1 and free_preg≠0 is written at tail+m, where m = count of preceding accepted lanes.
  - tail and free_count advance by the accepted count.
  - free_preg == 0 is silently dropped; p0 is the permanent x0 mapping.
- Simultaneous alloc and free in one cycle:
  - free_count_next = free_count - allocated + freed.
  - No bypass: freed registers are allocatable from the next cycle onward.
  - alloc_ready uses the current free_count only.
- Boundaries:
  - free_count == ALLOC_WIDTH with all lanes requesting: fires, count → 0, empty=1 next cycle.
  - free_count == 0 with only a free in the cycle: count → freed count, empty deasserts next cycle.
  - Pointer wrap PHYS_REGS-1 → 0 is seamless across lanes within one cycle.
  - A free that would raise free_count above PHYS_REGS-1 is a protocol violation.
    - Simulation assertion fires.
    - RTL behaviour undefined; the counter saturates at PHYS_REGS-1.
  - Duplicate free of the same register is a protocol violation; checked by the bench, not by RTL.
- Invariant: free_count == (tail - head) mod PHYS_REGS whenever free_count < PHYS_REGS.

Test Plan:
- Reset, then alloc_req=2'b11 for 3 cycles → alloc_preg = {32,33}, {34,35}, {36,37}; free_count 96→94→92→90.
- Sparse request alloc_req=2'b10 → lane1 gets next head entry (e.g. 38), lane0 drives 0, count −1.
- Drain to free_count=1, alloc_req=2'b11 → alloc_ready=0, head/count unchanged. Same cycle free_en=2'b01, free_preg=40 → next cycle count=2, ready=1, alloc returns {last remaining, 40}.
- Same-cycle alloc 2 + free 2 (regs 5, 0) → count net −1 (p0 dropped); reg 5 appears at the tail position.
- Cycle allocate/free through >PHYS_REGS total operations → pointers wrap; each register index is returned exactly once per lifetime (scoreboard); the count invariant holds every cycle.
- Assert rst mid-stream with alloc_req and free_en high → immediate count=96, head=0; first post-reset alloc returns {32,33}.
